sprite_rom_arbiter: RTL

Shares one synchronous sprite/tile ROM read port between up to N_REQ pixel requesters (scan-out, tank sprites, projectiles) in the VGA pixel-clock domain. Each cycle it grants at most one request, drives the ROM address, and routes the returned palette index back to the winner, tagged with its one-hot response strobe. Requester 0 is the scan-out path and can be given absolute priority; the others are served round-robin.

---
 rtl/sprite_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 40 ++++
 rtl/sprite_rom_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/sprite_arb_pkg.sv
// Shared constants, types and helpers for the sprite ROM arbiter.
package sprite_arb_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int ADDR_W_DEF  = 10;
  localparam int DATA_W_DEF  = 4;
  localparam int ROM_LAT_DEF = 1;

  typedef logic [N_REQ_DEF-1:0] req_vec_t;

  // Index of the set bit in a one-hot vector of up to 8 requesters; 0 when empty.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = idx | (oh[i] ? 3'(i) : 3'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first eligible requester at or after rr_ptr_i, wrapping.
module rr_pick
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible_i,
  input  logic [PW-1:0]    rr_ptr_i,
  output logic [PW-1:0]    winner_o,
  output logic             found_o
);

  logic [2*N_REQ-1:0] dbl_s;
  logic [2*N_REQ-1:0] one_s;
  logic [2*N_REQ-1:0] low_mask_s;
  logic [2*N_REQ-1:0] masked_s;
  logic               hit_s;
  logic               take_s;
  int                 pos_s;

  // Upper copy keeps bits below the pointer reachable, giving the wrap-around for free.
  always_comb begin
    dbl_s      = {eligible_i, eligible_i};
    one_s      = (2*N_REQ)'(1);
    low_mask_s = (one_s << rr_ptr_i) - one_s;
    masked_s   = dbl_s & ~low_mask_s;
    hit_s      = 1'b0;
    take_s     = 1'b0;
    pos_s      = 0;
    for (int i = 0; i < 2*N_REQ; i++) begin
      take_s = masked_s[i] & ~hit_s;
      pos_s  = take_s ? i : pos_s;
      hit_s  = hit_s | take_s;
    end
    winner_o = (pos_s >= N_REQ) ? PW'(pos_s - N_REQ) : PW'(pos_s);
    found_o  = hit_s;
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM read port among N_REQ requesters and
// routes each returned palette index back to its requester with a one-hot strobe.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROM_LAT = ROM_LAT_DEF
) (
  input  logic                    vga_clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic                    hi_prio_en,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_address,
  input  logic [DATA_W-1:0]       rom_q,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data
);

  localparam int PW = $clog2(N_REQ);

  logic [N_REQ-1:0]  eligible_s;
  logic [PW-1:0]     rr_winner_s;
  logic              rr_found_s;
  logic              prio_win_s;
  logic [PW-1:0]     win_idx_s;

  logic [N_REQ-1:0]  gnt_d, gnt_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [PW-1:0]     rr_ptr_d, rr_ptr_q;
  logic [N_REQ-1:0]  tag_q [ROM_LAT];
  logic [N_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_d, rsp_data_q;

  // A requester granted this cycle is masked so a stale req cannot win twice in a row.
  assign eligible_s = req & ~gnt_q;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_pick (
    .eligible_i (eligible_s),
    .rr_ptr_i   (rr_ptr_q),
    .winner_o   (rr_winner_s),
    .found_o    (rr_found_s)
  );

  // Grant, address and pointer next-state; priority wins of requester 0 leave rr_ptr alone.
  always_comb begin
    prio_win_s = hi_prio_en & eligible_s[0];
    win_idx_s  = prio_win_s ? PW'(0) : rr_winner_s;
    gnt_d      = '0;
    addr_d     = addr_q;
    rr_ptr_d   = rr_ptr_q;
    if (prio_win_s || rr_found_s) begin
      gnt_d[win_idx_s] = 1'b1;
      addr_d           = req_addr[win_idx_s*ADDR_W +: ADDR_W];
    end else begin
      addr_d = addr_q;
    end
    if (!prio_win_s && rr_found_s) begin
      if (rr_winner_s == PW'(N_REQ-1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = rr_winner_s + PW'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Response data is captured only when a tag reaches the last stage.
  always_comb begin
    if (|tag_q[ROM_LAT-1]) begin
      rsp_data_d = rom_q;
    end else begin
      rsp_data_d = rsp_data_q;
    end
  end

  // All arbiter state; reset discards any in-flight tags.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q       <= '0;
      addr_q      <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int k = 0; k < ROM_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      rr_ptr_q <= rr_ptr_d;
      tag_q[0] <= gnt_d;
      for (int k = 1; k < ROM_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      rsp_valid_q <= tag_q[ROM_LAT-1];
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign gnt         = gnt_q;
  assign rom_address = addr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;

endmodule
